spi_txn_scheduler: RTL and testbench

SPI_TXN_SCHEDULER -- requirements
Module: spi_txn_scheduler

---
 rtl/spi_txn_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_spi_txn_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_scheduler.sv
// ---------------------------------------------------------------------------
// spi_txn_scheduler
//
// Purpose:
//   Shares one SPI master between NREQ requesters. Requests are arbitrated
//   round-robin in IDLE. The winner's byte is handed to the master, and its
//   slave select is driven low for the whole transaction. The received byte
//   comes back as a one-cycle response tagged with the owner's index. After
//   each transaction, chip selects are held inactive for at least GAP_CYCLES
//   cycles.
//
// Optional feature:
//   `define SPI_SCHED_TIMEOUT_EN enables an XFER watchdog. If the master does
//   not report completion within TIMEOUT cycles, the transaction is aborted
//   with rsp_err=1 and rsp_data=8'h00. Without the macro, XFER waits
//   indefinitely and rsp_err is tied to 0.
//
// Ports:
//   CLK        in   clock, all state changes on the rising edge
//   reset      in   asynchronous reset, active low
//   req        in   [NREQ]   per-requester level request
//   req_data   in   [8*NREQ] byte i at [8i+7:8i], byte to send for requester i
//   gnt        out  [NREQ]   one-hot grant pulse (GRANT cycle)
//   rsp_valid  out  response pulse (RESP cycle)
//   rsp_id     out  [2]      owner of the response
//   rsp_data   out  [8]      byte received from the slave
//   rsp_err    out  response came from a watchdog abort
//   m_start    out  start pulse to the SPI master (first XFER cycle)
//   m_data     out  [8]      transmit byte, stable from GRANT to RESP
//   m_cs_n     out  [NREQ]   active-low slave selects
//   m_done     in   master byte-complete pulse
//   m_rx       in   [8]      master receive byte, valid with m_done
//   busy       out  high in every state except IDLE
//
// rsp_id is two bits wide, so NREQ may be at most 4.
// ---------------------------------------------------------------------------
module spi_txn_scheduler #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    output logic [1:0]        rsp_id,
    output logic [7:0]        rsp_data,
    output logic              rsp_err,
    output logic              m_start,
    output logic [7:0]        m_data,
    output logic [NREQ-1:0]   m_cs_n,
    input  logic              m_done,
    input  logic [7:0]        m_rx,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        XFER,
        RESP,
        GAP
    } state_t;

    state_t          state;
    logic [1:0]      last_granted;
    logic [1:0]      cur_id;
    logic [3:0]      gap_cnt;

    logic [1:0]      win_id;
    logic            win_found;
    logic [NREQ-1:0] win_onehot;

`ifdef SPI_SCHED_TIMEOUT_EN
    logic [7:0]      wd_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    // Round-robin pick. The search starts one past the last winner, and the
    // first requester found in that rotated order wins. The result is only
    // consumed in IDLE, so req changes in other states have no effect.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[(int'(last_granted) + 1 + k) % NREQ]) begin
                win_id    = 2'((int'(last_granted) + 1 + k) % NREQ);
                win_found = 1'b1;
            end
        end
        win_onehot = NREQ'(1) << win_id;
    end

    // Transaction sequencer. The pulse outputs (gnt, m_start, rsp_valid)
    // default low and are raised only on the edge that enters their state.
    // The slave select is pulled low when GRANT is entered and released
    // when RESP is left.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_granted <= 2'(NREQ - 1);
            cur_id       <= '0;
            gap_cnt      <= '0;
            gnt          <= '0;
            m_start      <= 1'b0;
            m_cs_n       <= '1;
            m_data       <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            busy         <= 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
            wd_cnt       <= '0;
            rsp_err      <= 1'b0;
`endif
        end else begin
            gnt       <= '0;
            m_start   <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state        <= GRANT;
                        gnt          <= win_onehot;
                        m_cs_n       <= ~win_onehot;
                        m_data       <= req_data[8*win_id +: 8];
                        cur_id       <= win_id;
                        last_granted <= win_id;
                        busy         <= 1'b1;
                    end
                end
                GRANT: begin
                    state   <= XFER;
                    m_start <= 1'b1;
`ifdef SPI_SCHED_TIMEOUT_EN
                    wd_cnt  <= '0;
`endif
                end
                XFER: begin
                    // While m_start is high we are in the first XFER cycle.
                    // A done seen there cannot belong to this transfer.
                    if (m_done && !m_start) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_data  <= m_rx;
`ifdef SPI_SCHED_TIMEOUT_EN
                        rsp_err   <= 1'b0;
                    end else if (wd_cnt == 8'(TIMEOUT)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_data  <= 8'h00;
                        rsp_err   <= 1'b1;
                    end else begin
                        wd_cnt    <= wd_cnt + 8'd1;
`endif
                    end
                end
                RESP: begin
                    state   <= GAP;
                    m_cs_n  <= '1;
                    gap_cnt <= '0;
                end
                GAP: begin
                    if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// ---------------------------------------------------------------------------
// tb_spi_txn_scheduler
//
// Directed testbench for spi_txn_scheduler, using the default parameters
// (NREQ=4, GAP_CYCLES=2, TIMEOUT=64).
//
// Inputs are driven 1 ns after the rising edge. Outputs are checked at the
// same point. A monitor samples 2 ns after the edge and logs grants,
// responses and the shortest all-inactive chip-select run between
// transactions. An optional slave model answers each m_start with m_done
// after a set delay, returning the complement of m_data.
// ---------------------------------------------------------------------------
module tb_spi_txn_scheduler;

    localparam int NREQ       = 4;
    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 64;

    logic              CLK = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [7:0]        rsp_data;
    logic              rsp_err;
    logic              m_start;
    logic [7:0]        m_data;
    logic [NREQ-1:0]   m_cs_n;
    logic              m_done;
    logic [7:0]        m_rx;
    logic              busy;

    int vectorCount = 0;
    int missCount   = 0;

    int         grantLog[$];
    int         rspIdLog[$];
    logic [7:0] rspDataLog[$];
    int         csHighRun;
    int         minGap;
    bit         seenTxn;

    bit autoSlave  = 1'b0;
    int slaveDelay = 3;
    int slaveCnt   = 0;

    logic [7:0] expData[4] = '{8'hEE, 8'hDD, 8'hCC, 8'hBB};
    int         latency;
    int         id2Count;

    spi_txn_scheduler #(
        .NREQ       (NREQ),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .m_start   (m_start),
        .m_data    (m_data),
        .m_cs_n    (m_cs_n),
        .m_done    (m_done),
        .m_rx      (m_rx),
        .busy      (busy)
    );

    // Free-running 100 MHz clock
    always #5 CLK = ~CLK;

    // Absolute time limit so a stuck run still terminates
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation ran too long, expected to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compares one observed value with its expected value and records the result
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives the request lines and the per-requester transmit bytes
    task automatic applyStimulus(input logic [NREQ-1:0] reqV,
                                 input logic [8*NREQ-1:0] dataV);
        req      = reqV;
        req_data = dataV;
    endtask

    // Advances one clock and lands 1 ns after the rising edge
    task automatic stepClock();
        @(posedge CLK);
        #1;
    endtask

    // Clears the monitor logs so each test starts with empty history
    task automatic clearLogs();
        grantLog.delete();
        rspIdLog.delete();
        rspDataLog.delete();
        csHighRun = 0;
        minGap    = 1000;
        seenTxn   = 1'b0;
    endtask

    // Holds reset for two cycles, then releases it into an IDLE cycle
    task automatic resetDut();
        reset     = 1'b0;
        autoSlave = 1'b0;
        slaveCnt  = 0;
        m_done    = 1'b0;
        m_rx      = 8'h00;
        applyStimulus('0, '0);
        repeat (2) stepClock();
        clearLogs();
        reset = 1'b1;
        stepClock();
    endtask

    // Monitor: logs grants and responses, and measures the gaps between
    // transactions in which all chip selects are inactive
    initial begin
        clearLogs();
        forever begin
            @(posedge CLK);
            #2;
            if (reset) begin
                for (int i = 0; i < NREQ; i++)
                    if (gnt[i]) grantLog.push_back(i);
                if (rsp_valid) begin
                    rspIdLog.push_back(int'(rsp_id));
                    rspDataLog.push_back(rsp_data);
                end
                if (m_cs_n == {NREQ{1'b1}}) begin
                    csHighRun++;
                end else begin
                    if (seenTxn && csHighRun > 0 && csHighRun < minGap)
                        minGap = csHighRun;
                    seenTxn   = 1'b1;
                    csHighRun = 0;
                end
            end
        end
    end

    // Slave model: answers each m_start with m_done after slaveDelay cycles
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (autoSlave) begin
                if (m_done) m_done = 1'b0;
                if (m_start) begin
                    slaveCnt = slaveDelay;
                end else if (slaveCnt > 0) begin
                    slaveCnt--;
                    if (slaveCnt == 0) begin
                        m_done = 1'b1;
                        m_rx   = ~m_data;
                    end
                end
            end
        end
    end

    initial begin
        // ---- Values driven while reset is held ----
        reset = 1'b0;
        m_done = 1'b0;
        m_rx = 8'h00;
        applyStimulus('0, '0);
        repeat (2) stepClock();
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_cs_n", 32'(m_cs_n), 32'hF);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_pulses", 32'({m_start, rsp_valid}), 32'h0);
        checkOutput("rst_rsp", 32'({rsp_id, rsp_err, rsp_data}), 32'h0);
        checkOutput("rst_m_data", 32'(m_data), 32'h0);
        reset = 1'b1;
        stepClock();

        // ---- Single request from requester 0 ----
        applyStimulus(4'b0001, {8'h44, 8'h33, 8'h22, 8'hA5});
        stepClock();
        checkOutput("single_gnt", 32'(gnt), 32'h1);
        checkOutput("single_m_data", 32'(m_data), 32'hA5);
        checkOutput("single_cs_n", 32'(m_cs_n), 32'hE);
        checkOutput("single_busy", 32'(busy), 32'h1);
        checkOutput("single_no_start_in_grant", 32'(m_start), 32'h0);
        applyStimulus(4'b0000, {8'h44, 8'h33, 8'h22, 8'hA5});
        stepClock();
        checkOutput("single_m_start", 32'(m_start), 32'h1);
        checkOutput("single_gnt_cleared", 32'(gnt), 32'h0);
        repeat (10) stepClock();
        checkOutput("single_start_one_cycle", 32'(m_start), 32'h0);
        checkOutput("single_no_early_rsp", 32'(rsp_valid), 32'h0);
        m_done = 1'b1;
        m_rx   = 8'h3C;
        stepClock();
        m_done = 1'b0;
        checkOutput("single_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("single_rsp_id", 32'(rsp_id), 32'h0);
        checkOutput("single_rsp_data", 32'(rsp_data), 32'h3C);
        checkOutput("single_rsp_err", 32'(rsp_err), 32'h0);
        checkOutput("single_cs_in_resp", 32'(m_cs_n), 32'hE);
        stepClock();
        checkOutput("single_gap_cs_n", 32'(m_cs_n), 32'hF);
        checkOutput("single_rsp_pulse", 32'(rsp_valid), 32'h0);
        checkOutput("single_rsp_hold", 32'(rsp_data), 32'h3C);
        stepClock();
        checkOutput("single_gap_busy", 32'(busy), 32'h1);
        stepClock();
        checkOutput("single_idle_busy", 32'(busy), 32'h0);

        // ---- Contention: all four requesters held ----
        resetDut();
        slaveDelay = 3;
        autoSlave  = 1'b1;
        applyStimulus(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
        for (int c = 0; c < 400 && grantLog.size() < 5; c++) stepClock();
        applyStimulus(4'b0000, {8'h44, 8'h33, 8'h22, 8'h11});
        for (int c = 0; c < 400 && rspIdLog.size() < 5; c++) stepClock();
        for (int c = 0; c < 20 && busy; c++) stepClock();
        checkOutput("cont_grant_count", 32'(grantLog.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < grantLog.size())
                checkOutput($sformatf("cont_grant_%0d", i), 32'(grantLog[i]), 32'(i % 4));
        checkOutput("cont_rsp_count", 32'(rspIdLog.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < rspIdLog.size()) begin
                checkOutput($sformatf("cont_rsp_id_%0d", i), 32'(rspIdLog[i]), 32'(i % 4));
                checkOutput($sformatf("cont_rsp_data_%0d", i), 32'(rspDataLog[i]),
                            32'(expData[i % 4]));
            end
        checkOutput("cont_min_gap", 32'(minGap), 32'(GAP_CYCLES + 1));
        autoSlave = 1'b0;

        // ---- Withdrawal: one-cycle req[2] pulse while busy ----
        resetDut();
        slaveDelay = 6;
        autoSlave  = 1'b1;
        applyStimulus(4'b0001, {8'h44, 8'h33, 8'h22, 8'h11});
        stepClock();
        applyStimulus(4'b0000, {8'h44, 8'h33, 8'h22, 8'h11});
        stepClock();
        applyStimulus(4'b0100, {8'h44, 8'h33, 8'h22, 8'h11});
        stepClock();
        applyStimulus(4'b0000, {8'h44, 8'h33, 8'h22, 8'h11});
        for (int c = 0; c < 50 && busy; c++) stepClock();
        repeat (5) stepClock();
        checkOutput("wd_grant_count", 32'(grantLog.size()), 32'd1);
        if (grantLog.size() > 0)
            checkOutput("wd_grant_id", 32'(grantLog[0]), 32'd0);
        id2Count = 0;
        foreach (rspIdLog[i]) if (rspIdLog[i] == 2) id2Count++;
        checkOutput("wd_no_id2_rsp", 32'(id2Count), 32'd0);
        checkOutput("wd_rsp_count", 32'(rspIdLog.size()), 32'd1);
        checkOutput("wd_idle", 32'(busy), 32'h0);
        autoSlave = 1'b0;

        // ---- Watchdog: no m_done from the master ----
        resetDut();
        applyStimulus(4'b0010, {8'h44, 8'h33, 8'h22, 8'h11});
        stepClock();
        applyStimulus(4'b0000, {8'h44, 8'h33, 8'h22, 8'h11});
        stepClock();
        checkOutput("to_m_start", 32'(m_start), 32'h1);
`ifdef SPI_SCHED_TIMEOUT_EN
        latency = 0;
        for (int c = 1; c <= TIMEOUT + 50; c++) begin
            stepClock();
            if (rsp_valid) begin
                latency = c;
                break;
            end
        end
        checkOutput("to_latency", 32'(latency), 32'(TIMEOUT + 1));
        checkOutput("to_rsp_err", 32'(rsp_err), 32'h1);
        checkOutput("to_rsp_data", 32'(rsp_data), 32'h00);
        checkOutput("to_rsp_id", 32'(rsp_id), 32'h1);
`else
        repeat (150) stepClock();
        checkOutput("to_busy_stuck", 32'(busy), 32'h1);
        checkOutput("to_no_rsp", 32'(rspIdLog.size()), 32'd0);
        checkOutput("to_cs_held", 32'(m_cs_n), 32'hD);
        checkOutput("to_err_zero", 32'(rsp_err), 32'h0);
`endif

        // ---- Reset asserted three cycles after m_start ----
        resetDut();
        applyStimulus(4'b0100, {8'h44, 8'h33, 8'h22, 8'h11});
        stepClock();
        checkOutput("rx_gnt", 32'(gnt), 32'h4);
        applyStimulus(4'b0000, {8'h44, 8'h33, 8'h22, 8'h11});
        stepClock();
        repeat (3) stepClock();
        checkOutput("rx_cs_before", 32'(m_cs_n), 32'hB);
        reset = 1'b0;
        #1;
        checkOutput("rx_cs_now", 32'(m_cs_n), 32'hF);
        checkOutput("rx_busy_now", 32'(busy), 32'h0);
        checkOutput("rx_m_data_now", 32'(m_data), 32'h0);
        repeat (2) stepClock();
        checkOutput("rx_no_rsp_valid", 32'(rsp_valid), 32'h0);
        applyStimulus(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
        reset = 1'b1;
        stepClock();
        checkOutput("rx_first_gnt", 32'(gnt), 32'h1);
        checkOutput("rx_no_rsp_log", 32'(rspIdLog.size()), 32'd0);
        applyStimulus(4'b0000, {8'h44, 8'h33, 8'h22, 8'h11});

        // ---- Stray m_done in IDLE, the m_start cycle, and GAP ----
        resetDut();
        m_done = 1'b1;
        stepClock();
        m_done = 1'b0;
        checkOutput("stray_idle_busy", 32'(busy), 32'h0);
        checkOutput("stray_idle_rsp", 32'(rsp_valid), 32'h0);
        applyStimulus(4'b0001, {8'h44, 8'h33, 8'h22, 8'h77});
        stepClock();
        applyStimulus(4'b0000, {8'h44, 8'h33, 8'h22, 8'h77});
        stepClock();
        checkOutput("stray_start", 32'(m_start), 32'h1);
        m_done = 1'b1;
        m_rx   = 8'h99;
        stepClock();
        m_done = 1'b0;
        checkOutput("stray_start_rsp", 32'(rsp_valid), 32'h0);
        checkOutput("stray_start_cs", 32'(m_cs_n), 32'hE);
        stepClock();
        checkOutput("stray_still_xfer", 32'(rsp_valid), 32'h0);
        m_done = 1'b1;
        m_rx   = 8'h5A;
        stepClock();
        m_done = 1'b0;
        checkOutput("stray_real_rsp", 32'(rsp_valid), 32'h1);
        checkOutput("stray_real_data", 32'(rsp_data), 32'h5A);
        stepClock();
        m_done = 1'b1;
        stepClock();
        m_done = 1'b0;
        checkOutput("stray_gap_rsp", 32'(rsp_valid), 32'h0);
        checkOutput("stray_gap_busy", 32'(busy), 32'h1);
        stepClock();
        checkOutput("stray_gap_to_idle", 32'(busy), 32'h0);
        checkOutput("stray_rsp_count", 32'(rspIdLog.size()), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
